// File: rtl/decode_stage.sv
// decode_stage: decodes up to DECODE_WIDTH RV32 instructions per fetch bundle
// into register indices, class code and sign-extended immediate. It presents
// the decoded bundle through an output register backed by one skid register.
// The skid register absorbs rename back-pressure.
module decode_stage #(
    parameter int DECODE_WIDTH = 4,
    parameter int FSQ_W        = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DECODE_WIDTH-1:0]   in_en,
    input  logic [32*DECODE_WIDTH-1:0] in_inst,
    input  logic [FSQ_W-1:0]          in_fsq_idx,
    output logic                      in_stall,
    input  logic                      redirect,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DECODE_WIDTH-1:0]   out_en,
    output logic [FSQ_W-1:0]          out_fsq_idx,
    output logic [5*DECODE_WIDTH-1:0] out_rd,
    output logic [5*DECODE_WIDTH-1:0] out_rs1,
    output logic [5*DECODE_WIDTH-1:0] out_rs2,
    output logic [3*DECODE_WIDTH-1:0] out_type,
    output logic [32*DECODE_WIDTH-1:0] out_imm,
    output logic [DECODE_WIDTH-1:0]   out_illegal
);

    localparam logic [2:0] T_INT     = 3'd0;
    localparam logic [2:0] T_BRANCH  = 3'd1;
    localparam logic [2:0] T_JUMP    = 3'd2;
    localparam logic [2:0] T_LOAD    = 3'd3;
    localparam logic [2:0] T_STORE   = 3'd4;
    localparam logic [2:0] T_SYSTEM  = 3'd5;
    localparam logic [2:0] T_ILLEGAL = 3'd7;

    // Every slot contributes 52 bits: en, rd, rs1, rs2, type, imm and illegal.
    // The FSQ index adds FSQ_W bits once for the whole bundle.
    localparam int BUNDLE_W = DECODE_WIDTH * 52 + FSQ_W;

    logic [5*DECODE_WIDTH-1:0]  dec_rd;
    logic [5*DECODE_WIDTH-1:0]  dec_rs1;
    logic [5*DECODE_WIDTH-1:0]  dec_rs2;
    logic [3*DECODE_WIDTH-1:0]  dec_type;
    logic [32*DECODE_WIDTH-1:0] dec_imm;
    logic [DECODE_WIDTH-1:0]    dec_illegal;

    genvar gi;
    generate
        for (gi = 0; gi < DECODE_WIDTH; gi++) begin : g_slot
            logic [31:0] inst;
            logic [6:0]  opcode;
            logic [2:0]  cls;
            logic [31:0] imm;
            logic [4:0]  rd;
            logic [4:0]  rs1;
            logic [4:0]  rs2;
            logic        keep;

            assign inst   = in_inst[32*gi +: 32];
            assign opcode = inst[6:0];

            // Classify the slot by its opcode. Compressed encodings are illegal.
            always_comb begin
                cls = T_ILLEGAL;
                if (inst[1:0] == 2'b11) begin
                    case (opcode)
                        7'h33, 7'h13, 7'h37, 7'h17: cls = T_INT;
                        7'h63:                      cls = T_BRANCH;
                        7'h6F, 7'h67:               cls = T_JUMP;
                        7'h03:                      cls = T_LOAD;
                        7'h23:                      cls = T_STORE;
                        7'h73, 7'h0F:               cls = T_SYSTEM;
                        default:                    cls = T_ILLEGAL;
                    endcase
                end
            end

            // Pick the immediate format from the opcode. R-type, fence and illegal slots give 0.
            always_comb begin
                imm = 32'h0;
                case (opcode)
                    7'h13, 7'h03, 7'h67, 7'h73:
                        imm = {{20{inst[31]}}, inst[31:20]};
                    7'h23:
                        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                    7'h63:
                        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                    7'h37, 7'h17:
                        imm = {inst[31:12], 12'h000};
                    7'h6F:
                        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                    default:
                        imm = 32'h0;
                endcase
            end

            // Mask the raw register fields that the instruction class does not use.
            always_comb begin
                rd  = inst[11:7];
                rs1 = inst[19:15];
                rs2 = 5'd0;
                if (cls == T_BRANCH || cls == T_STORE)
                    rd = 5'd0;
                if (opcode == 7'h37 || opcode == 7'h17 || opcode == 7'h6F)
                    rs1 = 5'd0;
                if (opcode == 7'h33 || opcode == 7'h63 || opcode == 7'h23)
                    rs2 = inst[24:20];
            end

            // Invalid and illegal slots present all-zero fields. An illegal slot still reports type 7.
            assign keep = in_en[gi] && (cls != T_ILLEGAL);

            assign dec_rd[5*gi +: 5]    = keep ? rd  : 5'd0;
            assign dec_rs1[5*gi +: 5]   = keep ? rs1 : 5'd0;
            assign dec_rs2[5*gi +: 5]   = keep ? rs2 : 5'd0;
            assign dec_imm[32*gi +: 32] = keep ? imm : 32'h0;
            assign dec_type[3*gi +: 3]  = in_en[gi] ? cls : 3'd0;
            assign dec_illegal[gi]      = in_en[gi] && (cls == T_ILLEGAL);
        end
    endgenerate

    logic [BUNDLE_W-1:0] dec_bundle;
    logic [BUNDLE_W-1:0] out_bundle_reg;
    logic [BUNDLE_W-1:0] skid_bundle_reg;
    logic                out_valid_reg;
    logic                skid_valid_reg;
    logic                accept;
    logic                out_free;

    assign dec_bundle = {in_en, in_fsq_idx, dec_rd, dec_rs1, dec_rs2,
                         dec_type, dec_imm, dec_illegal};

    assign {out_en, out_fsq_idx, out_rd, out_rs1, out_rs2,
            out_type, out_imm, out_illegal} = out_bundle_reg;

    assign out_valid = out_valid_reg;
    assign in_stall  = skid_valid_reg;

    // A bundle arriving during a redirect is dropped. A full skid blocks acceptance.
    assign accept   = (|in_en) && !skid_valid_reg && !redirect;
    assign out_free = !out_valid_reg || out_ready;

    // Output/skid pipeline: the skid drains first, so bundle order is preserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_bundle_reg  <= '0;
            skid_bundle_reg <= '0;
            out_valid_reg   <= 1'b0;
            skid_valid_reg  <= 1'b0;
        end else if (redirect) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_reg) begin
                out_bundle_reg <= skid_bundle_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                out_bundle_reg <= dec_bundle;
                out_valid_reg  <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            skid_bundle_reg <= dec_bundle;
            skid_valid_reg  <= 1'b1;
        end
    end

endmodule
